// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter
//   Shares one downstream FIFO enqueue port between NREQ requesters.
//   Each requester owns a one-entry holding slot. A registered output stage
//   is refilled from the valid slots in round-robin order and presents its
//   beat on the downstream EN/RDY enqueue port.
//
// Ports
//   CLK              clock, rising edge
//   RST_N            asynchronous active-low reset
//   EN_req_enqueue   per-requester enqueue strobe (legal only while RDY=1)
//   req_data         requester i data at [i*DW +: DW]
//   RDY_req_enqueue  requester i slot empty
//   EN_out_enqueue   downstream enqueue strobe (out_valid & RDY_out_enqueue)
//   out_data         downstream data
//   out_src          requester index of the current out_data
//   RDY_out_enqueue  downstream FIFO can accept
//   beat_count       beats delivered downstream, wraps modulo 2^CW
//   err_overrun      sticky per-requester overrun flags
module fifo_enq_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NREQ-1:0]    EN_req_enqueue,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    RDY_req_enqueue,
  output logic               EN_out_enqueue,
  output logic [DW-1:0]      out_data,
  output logic [2:0]         out_src,
  input  logic               RDY_out_enqueue,
  output logic [CW-1:0]      beat_count,
  output logic [NREQ-1:0]    err_overrun
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] slot_valid;
  logic [DW-1:0]   slot_data [NREQ];
  logic            out_valid;
  logic [PW-1:0]   rr_ptr;

  // Round-robin winner among the valid slots, starting at rr_ptr.
  logic            win_found;
  logic [NREQ-1:0] win_oh;
  logic [DW-1:0]   win_data;
  logic [2:0]      win_src;
  logic [PW-1:0]   win_next;

  logic transfer;
  logic load;

  // Slot readiness depends only on slot state, never on downstream RDY.
  assign RDY_req_enqueue = ~slot_valid;
  assign EN_out_enqueue  = out_valid & RDY_out_enqueue;
  assign transfer        = EN_out_enqueue;
  // The stage may be refilled when empty or when its beat leaves this cycle.
  assign load            = (~out_valid | transfer) & (|slot_valid);

  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated values within the same evaluation.
  always_comb begin
    int            idx;
    logic [PW-1:0] sel;
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    win_found = 1'b0;
    win_oh    = '0;
    win_data  = '0;
    win_src   = '0;
    win_next  = '0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PW'(idx);
      if (!win_found && slot_valid[sel]) begin
        win_found   = 1'b1;
        win_oh[sel] = 1'b1;
        win_data    = slot_data[sel];
        win_src     = 3'(sel);
        win_next    = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Control state: slot occupancy, output stage, pointer, counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_valid  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_src     <= '0;
      rr_ptr      <= '0;
      beat_count  <= '0;
      err_overrun <= '0;
    end else begin
      // A slot being loaded is valid, so it cannot also accept an enqueue:
      // the clear and the set below never touch the same bit.
      slot_valid  <= (slot_valid & ~(load ? win_oh : '0))
                   | (EN_req_enqueue & ~slot_valid);
      err_overrun <= err_overrun | (EN_req_enqueue & slot_valid);

      if (transfer) beat_count <= beat_count + 1'b1;

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_src   <= win_src;
        rr_ptr    <= win_next;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: slot payload storage has no reset; slot_valid alone says whether
  // a slot's contents mean anything, so stale data is never observed.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (EN_req_enqueue[i] && !slot_valid[i]) slot_data[i] <= req_data[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed bench for fifo_enq_arbiter (NREQ=3, DW=32, CW=16).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_fifo_enq_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int CW   = 16;

  logic               CLK;
  logic               RST_N;
  logic [NREQ-1:0]    EN_req_enqueue;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    RDY_req_enqueue;
  logic               EN_out_enqueue;
  logic [DW-1:0]      out_data;
  logic [2:0]         out_src;
  logic               RDY_out_enqueue;
  logic [CW-1:0]      beat_count;
  logic [NREQ-1:0]    err_overrun;

  int total = 0;
  int bad   = 0;
  int exp_beats;

  fifo_enq_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .EN_req_enqueue  (EN_req_enqueue),
    .req_data        (req_data),
    .RDY_req_enqueue (RDY_req_enqueue),
    .EN_out_enqueue  (EN_out_enqueue),
    .out_data        (out_data),
    .out_src         (out_src),
    .RDY_out_enqueue (RDY_out_enqueue),
    .beat_count      (beat_count),
    .err_overrun     (err_overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    #3 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    tick();
  endtask

  initial begin
    RST_N           = 1'b0;
    EN_req_enqueue  = '0;
    req_data        = '0;
    RDY_out_enqueue = 1'b1;
    #22 RST_N = 1'b1;
    tick();

    // Reset state
    check("rst_rdy", RDY_req_enqueue, 3'b111);
    check("rst_en_out", EN_out_enqueue, 1'b0);
    check("rst_beats", beat_count, 16'h0);
    check("rst_err", err_overrun, 3'b000);
    check("rst_data", out_data, 32'h0);
    check("rst_src", out_src, 3'd0);

    // Single beat: two cycles from EN to EN_out_enqueue
    EN_req_enqueue = 3'b001;
    set_data(0, 32'hA5A5_A5A5);
    tick();
    EN_req_enqueue = '0;
    check("single_slot_full", RDY_req_enqueue, 3'b110);
    check("single_not_yet", EN_out_enqueue, 1'b0);
    tick();
    check("single_en_out", EN_out_enqueue, 1'b1);
    check("single_data", out_data, 32'hA5A5_A5A5);
    check("single_src", out_src, 3'd0);
    check("single_slot_free", RDY_req_enqueue, 3'b111);
    tick();
    check("single_beats", beat_count, 16'd1);
    check("single_idle", EN_out_enqueue, 1'b0);

    // Round-robin from a fresh pointer
    do_reset();
    EN_req_enqueue = 3'b111;
    set_data(0, 32'd1);
    set_data(1, 32'd2);
    set_data(2, 32'd3);
    tick();
    EN_req_enqueue = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rr_en_%0d", i), EN_out_enqueue, 1'b1);
      check($sformatf("rr_src_%0d", i), out_src, 3'(i));
      check($sformatf("rr_data_%0d", i), out_data, 32'(i + 1));
      check($sformatf("rr_beats_%0d", i), beat_count, 16'(i));
      tick();
    end
    check("rr_idle", EN_out_enqueue, 1'b0);
    check("rr_beats", beat_count, 16'd3);

    // Backpressure: beat 0x11 held while downstream is not ready
    RDY_out_enqueue = 1'b0;
    EN_req_enqueue  = 3'b001;
    set_data(0, 32'h11);
    tick();
    EN_req_enqueue = '0;
    tick();
    check("bp_slot_drained", RDY_req_enqueue[0], 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_data_%0d", i), out_data, 32'h11);
      check($sformatf("bp_hold_en_%0d", i), EN_out_enqueue, 1'b0);
      tick();
    end
    check("bp_beats_frozen", beat_count, 16'd3);
    RDY_out_enqueue = 1'b1;
    #1;
    check("bp_release_en", EN_out_enqueue, 1'b1);
    tick();
    check("bp_one_transfer", EN_out_enqueue, 1'b0);
    check("bp_beats", beat_count, 16'd4);
    tick();
    check("bp_beats_stable", beat_count, 16'd4);

    // Overrun on slot 1 while it is full and downstream is stalled
    RDY_out_enqueue = 1'b0;
    EN_req_enqueue  = 3'b010;
    set_data(1, 32'h22);
    tick();
    EN_req_enqueue = '0;
    tick();
    check("ov_stage", out_data, 32'h22);
    EN_req_enqueue = 3'b010;
    set_data(1, 32'h33);
    tick();
    EN_req_enqueue = 3'b010;
    set_data(1, 32'h44);
    tick();
    EN_req_enqueue = '0;
    check("ov_err_first", err_overrun, 3'b010);
    tick();
    EN_req_enqueue = 3'b010;
    set_data(1, 32'h55);
    tick();
    EN_req_enqueue = '0;
    check("ov_err", err_overrun, 3'b010);
    check("ov_rdy", RDY_req_enqueue, 3'b101);
    check("ov_stall_en", EN_out_enqueue, 1'b0);
    RDY_out_enqueue = 1'b1;
    #1;
    check("ov_out1_en", EN_out_enqueue, 1'b1);
    check("ov_out1_data", out_data, 32'h22);
    check("ov_out1_src", out_src, 3'd1);
    tick();
    check("ov_out2_en", EN_out_enqueue, 1'b1);
    check("ov_out2_data", out_data, 32'h33);
    check("ov_out2_src", out_src, 3'd1);
    tick();
    check("ov_idle", EN_out_enqueue, 1'b0);
    check("ov_beats", beat_count, 16'd6);
    check("ov_err_sticky", err_overrun, 3'b010);

    // Stream two requesters until the counter reaches 0xFFFF
    exp_beats = 6;
    for (int n = 0; n < 70000; n++) begin
      if (exp_beats == 16'hFFFF) break;
      EN_req_enqueue = RDY_req_enqueue & 3'b011;
      if (EN_out_enqueue) exp_beats++;
      tick();
    end
    RDY_out_enqueue = 1'b0;
    EN_req_enqueue  = RDY_req_enqueue;
    tick();
    EN_req_enqueue = '0;
    tick();
    check("wrap_reached", exp_beats, 32'hFFFF);
    check("wrap_pre", beat_count, 16'hFFFF);
    check("wrap_stall_en", EN_out_enqueue, 1'b0);
    RDY_out_enqueue = 1'b1;
    tick();
    RDY_out_enqueue = 1'b0;
    check("wrap_zero", beat_count, 16'h0);
    check("wrap_err_sticky", err_overrun, 3'b010);

    // Asynchronous reset between edges with beats held
    #3 RST_N = 1'b0;
    RDY_out_enqueue = 1'b1;
    #1;
    check("arst_en_out", EN_out_enqueue, 1'b0);
    check("arst_rdy", RDY_req_enqueue, 3'b111);
    check("arst_data", out_data, 32'h0);
    check("arst_src", out_src, 3'd0);
    check("arst_err", err_overrun, 3'b000);
    check("arst_beats", beat_count, 16'h0);
    #2 RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("arst_no_stale_%0d", i), EN_out_enqueue, 1'b0);
    end
    check("arst_beats_after", beat_count, 16'h0);
    check("arst_rdy_after", RDY_req_enqueue, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
